// File: rtl/mem_responder.sv
// mem_responder: single-ported word memory behind a val/rdy request and
// response interface. One request is in flight at a time. The response
// appears a fixed LATENCY cycles after the request is accepted. It is held
// until the consumer takes it.
//
// Parameters
//   WORDS    storage depth in 32-bit words (power of two, 4..4096)
//   LATENCY  cycles from request acceptance to memresp_val (1..8)
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous, active-low reset
//   memreq_val    request offered
//   memreq_rdy    responder can accept a request (IDLE and not in reset)
//   memreq_type   0 = read, 1 = write
//   memreq_addr   byte address
//   memreq_wdata  write data
//   memresp_val   response offered
//   memresp_rdy   consumer accepts the response
//   memresp_type  echo of the request type
//   memresp_data  read data, or 0 for writes and errors
//   memresp_err   request was misaligned or out of range

module mem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_type,
    input  logic [31:0] memreq_addr,
    input  logic [31:0] memreq_wdata,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_type,
    output logic [31:0] memresp_data,
    output logic        memresp_err
);

    localparam int IDX_W = $clog2(WORDS);

    // WAIT covers LATENCY-1 cycles, so the counter starts at LATENCY-2 and
    // the exit happens on the cycle it reads zero.
    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [31:0]      mem [WORDS];

    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic             req_fire;

    assign req_idx  = memreq_addr[IDX_W+1:2];
    assign req_err  = (memreq_addr[1:0] != 2'b00) ||
                      (memreq_addr[31:IDX_W+2] != '0);

    // Reset must block acceptance in the same cycle, so rst is folded in
    // combinationally rather than waiting for the state register.
    assign memreq_rdy = rst && (state == IDLE);
    assign req_fire   = memreq_val && memreq_rdy;

    // NOTE: storage has no reset branch; clearing a RAM on reset would force
    // it into flops and is not wanted here, so it lives in its own block.
    always_ff @(posedge clk) begin
        if (req_fire && memreq_type && !req_err) begin
            mem[req_idx] <= memreq_wdata;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            memresp_val  <= 1'b0;
            memresp_type <= 1'b0;
            memresp_data <= '0;
            memresp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        // Read data is captured here, so later writes cannot
                        // alter a response that is already pending.
                        memresp_type <= memreq_type;
                        memresp_err  <= req_err;
                        memresp_data <= (!memreq_type && !req_err) ? mem[req_idx] : '0;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            memresp_val <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state       <= RESP;
                        memresp_val <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (memresp_rdy) begin
                        state       <= IDLE;
                        memresp_val <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    memresp_val <= 1'b0;
                end
            endcase
        end
    end

endmodule
